// File: rtl/jpeg_bit_buffer.sv
// jpeg_bit_buffer
//   Scan-data front end for the entropy decoder. It accepts IN_W-bit words,
//   strips JPEG byte stuffing (FF00 -> FF), drops fill bytes (FF FF), and
//   stops at markers. The surviving bytes are packed into an MSB-aligned bit
//   buffer that the Huffman decoder reads through a PEEK_W-bit window.
//
// Ports
//   clk, rst          clock; synchronous reset, active low
//   data_in/valid_in  scan word in; byte 0 is data_in[IN_W-1 -: 8]
//   request           ready for a word (staging empty, no marker pending)
//   peek/fill         next PEEK_W bits (oldest at MSB) / valid bit count
//   consume_en/consume  drop 'consume' bits this cycle (clamped to fill)
//   align             drop (fill mod 8) bits after the consume
//   marker_hit/code   marker found, extraction paused / its second byte
//   marker_ack        release a pending marker
//   clear             soft flush, same end state as reset
module jpeg_bit_buffer #(
    parameter int IN_W   = 32,
    parameter int PEEK_W = 32,
    parameter int BUF_W  = 64,
    parameter int CNT_W  = $clog2(BUF_W + 1),
    parameter int CONS_W = $clog2(PEEK_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   data_in,
    input  logic              valid_in,
    output logic              request,
    output logic [PEEK_W-1:0] peek,
    output logic [CNT_W-1:0]  fill,
    input  logic              consume_en,
    input  logic [CONS_W-1:0] consume,
    input  logic              align,
    output logic              marker_hit,
    output logic [7:0]        marker_code,
    input  logic              marker_ack,
    input  logic              clear
);

    localparam int NB    = IN_W / 8;
    localparam int IDX_W = $clog2(NB + 1);

    logic [IN_W-1:0]  stg_q, stg_d;      // current byte always at the top
    logic             stg_vld_q, stg_vld_d;
    logic [IDX_W-1:0] rem_q, rem_d;      // bytes left in staging
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             prev_ff_q, prev_ff_d;
    logic             hit_q, hit_d;
    logic [7:0]       code_q, code_d;

    logic [CNT_W-1:0] cons_amt, fill_c, algn_amt, fill_a;
    logic [7:0]       cur, app_byte;
    logic             room, app_en, adv;

    assign request     = rst && !stg_vld_q && !hit_q && !clear;
    assign peek        = buf_q[BUF_W-1 -: PEEK_W];
    assign fill        = fill_q;
    assign marker_hit  = hit_q;
    assign marker_code = code_q;
    assign cur         = stg_q[IN_W-1 -: 8];

    always_comb begin
        // removal: consume first (clamped), then align on the reduced fill
        cons_amt = '0;
        if (consume_en)
            cons_amt = (CNT_W'(consume) > fill_q) ? fill_q : CNT_W'(consume);
        fill_c   = fill_q - cons_amt;
        algn_amt = align ? CNT_W'(fill_c[2:0]) : '0;
        fill_a   = fill_c - algn_amt;
        // space check uses the fill after consume only
        room     = fill_c <= CNT_W'(BUF_W - 8);

        app_en    = 1'b0;
        app_byte  = cur;
        adv       = 1'b0;
        prev_ff_d = prev_ff_q;
        hit_d     = hit_q;
        code_d    = code_q;

        if (stg_vld_q && !hit_q) begin
            if (!prev_ff_q) begin
                if (cur == 8'hFF) begin
                    prev_ff_d = 1'b1;
                    adv       = 1'b1;
                end else if (room) begin
                    app_en = 1'b1;
                    adv    = 1'b1;
                end
            end else begin
                if (cur == 8'h00) begin
                    // stuffed FF: needs space, otherwise hold everything
                    if (room) begin
                        app_en    = 1'b1;
                        app_byte  = 8'hFF;
                        prev_ff_d = 1'b0;
                        adv       = 1'b1;
                    end
                end else if (cur == 8'hFF) begin
                    adv = 1'b1;                  // fill byte, keep prev_ff
                end else begin
                    hit_d     = 1'b1;
                    code_d    = cur;
                    prev_ff_d = 1'b0;
                    adv       = 1'b1;
                end
            end
        end

        if (hit_q && marker_ack)
            hit_d = 1'b0;

        buf_d = buf_q << (cons_amt + algn_amt);
        if (app_en)
            buf_d = buf_d | ({app_byte, {(BUF_W-8){1'b0}}} >> fill_a);
        fill_d = fill_a + (app_en ? CNT_W'(8) : '0);

        stg_d     = stg_q;
        stg_vld_d = stg_vld_q;
        rem_d     = rem_q;
        if (adv) begin
            if (rem_q == IDX_W'(1)) begin
                stg_vld_d = 1'b0;
            end else begin
                stg_d = stg_q << 8;
                rem_d = rem_q - IDX_W'(1);
            end
        end
        // request implies staging is empty, so this never overlaps adv
        if (valid_in && request) begin
            stg_d     = data_in;
            stg_vld_d = 1'b1;
            rem_d     = IDX_W'(NB);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
            rem_q     <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            prev_ff_q <= 1'b0;
            hit_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
            rem_q     <= rem_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            prev_ff_q <= prev_ff_d;
            hit_q     <= hit_d;
            code_q    <= code_d;
        end
    end

endmodule
